multi_alarm_core: RTL and testbench

Parametrised successor to the single-alarm datapath: one block holding the BCD time-of-day counter, NUM_ALARMS independently enabled alarm registers, and a per-channel ring/snooze/timeout state machine. It sits between the keyboard controller (load strobes, BCD key buffer), the 1-minute pulse from the time generator, and the snooze/off button pulses. It drives the 7-segment mux input and the alarm LED.

---
 rtl/multi_alarm_core.sv | 157 +++++++++++++++
 tb/tb_multi_alarm_core.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_core.sv
// rtl/multi_alarm_core.sv - BCD time-of-day counter with NUM_ALARMS ring/snooze/timeout alarm channels
module multi_alarm_core #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 9,
    parameter int RING_TIMEOUT_MIN = 60,
    parameter int SEL_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  one_minute,
    input  logic                  load_time,
    input  logic [15:0]           time_in,
    input  logic                  load_alarm,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic [15:0]           alarm_in,
    input  logic                  alarm_en_in,
    input  logic                  do_snooze,
    input  logic                  stop_alarm,
    input  logic                  show_alarm,
    input  logic [SEL_W-1:0]      show_sel,
    output logic [15:0]           current_time,
    output logic [15:0]           display,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  sound_alarm,
    output logic [SEL_W-1:0]      active_alarm
);

    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} ch_state_t;

    localparam logic [5:0] SNZ_LOAD = 6'(SNOOZE_MIN);
    localparam logic [7:0] RT       = 8'(RING_TIMEOUT_MIN);

    logic [15:0] alarm_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_en;
    ch_state_t   state      [NUM_ALARMS];
    logic [7:0]  ring_cnt   [NUM_ALARMS];
    logic [5:0]  snz_cnt    [NUM_ALARMS];

    logic [15:0] next_time;
    logic [15:0] shown_alarm;
    logic        time_load_ok;
    logic        alarm_load_ok;

    function automatic logic bcd_ok(input logic [15:0] t);
        bcd_ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) &&
                 ((t[15:12] < 4'd2) || ((t[15:12] == 4'd2) && (t[11:8] <= 4'd3)));
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] h1, h0, m1, m0;
        {h1, h0, m1, m0} = t;
        if (m0 != 4'd9) begin
            m0 = m0 + 4'd1;
        end else begin
            m0 = 4'd0;
            if (m1 != 4'd5) begin
                m1 = m1 + 4'd1;
            end else begin
                m1 = 4'd0;
                if (h1 == 4'd2 && h0 == 4'd3) begin
                    h1 = 4'd0;
                    h0 = 4'd0;
                end else if (h0 == 4'd9) begin
                    h0 = 4'd0;
                    h1 = h1 + 4'd1;
                end else begin
                    h0 = h0 + 4'd1;
                end
            end
        end
        bcd_inc = {h1, h0, m1, m0};
    endfunction

    assign next_time     = bcd_inc(current_time);
    assign time_load_ok  = load_time && bcd_ok(time_in);
    assign alarm_load_ok = load_alarm && bcd_ok(alarm_in) && (32'(alarm_sel) < NUM_ALARMS);

    always_comb begin
        shown_alarm = 16'h0000;
        if (32'(show_sel) < NUM_ALARMS)
            shown_alarm = alarm_time[show_sel];
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            current_time <= 16'h0000;
            display      <= 16'h0000;
            alarm_en     <= '0;
            for (int c = 0; c < NUM_ALARMS; c++) begin
                alarm_time[c] <= 16'h0000;
                state[c]      <= ST_IDLE;
                ring_cnt[c]   <= 8'd0;
                snz_cnt[c]    <= 6'd0;
            end
        end else begin
            if (time_load_ok)
                current_time <= time_in;
            else if (one_minute)
                current_time <= next_time;

            display <= show_alarm ? shown_alarm : current_time;

            for (int c = 0; c < NUM_ALARMS; c++) begin
                if (alarm_load_ok && (32'(alarm_sel) == c)) begin
                    alarm_time[c] <= alarm_in;
                    alarm_en[c]   <= alarm_en_in;
                    state[c]      <= ST_IDLE;
                    ring_cnt[c]   <= 8'd0;
                    snz_cnt[c]    <= 6'd0;
                end else if (stop_alarm) begin
                    // stop also masks a trigger that would land in the same cycle
                    state[c] <= ST_IDLE;
                end else if (do_snooze && state[c] == ST_RING) begin
                    state[c]   <= ST_SNOOZE;
                    snz_cnt[c] <= SNZ_LOAD;
                end else if (one_minute) begin
                    case (state[c])
                        ST_IDLE: begin
                            if (alarm_en[c] && !time_load_ok && alarm_time[c] == next_time) begin
                                state[c]    <= ST_RING;
                                ring_cnt[c] <= 8'd0;
                            end
                        end
                        ST_RING: begin
                            ring_cnt[c] <= ring_cnt[c] + 8'd1;
                            if (RT != 8'd0 && (ring_cnt[c] + 8'd1) == RT)
                                state[c] <= ST_IDLE;
                        end
                        ST_SNOOZE: begin
                            if (snz_cnt[c] == 6'd1) begin
                                state[c]    <= ST_RING;
                                ring_cnt[c] <= 8'd0;
                                snz_cnt[c]  <= 6'd0;
                            end else begin
                                snz_cnt[c] <= snz_cnt[c] - 6'd1;
                            end
                        end
                        default: state[c] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        ringing      = '0;
        active_alarm = '0;
        for (int c = 0; c < NUM_ALARMS; c++)
            ringing[c] = (state[c] == ST_RING);
        for (int c = NUM_ALARMS - 1; c >= 0; c--)
            if (ringing[c])
                active_alarm = SEL_W'(c);
    end

    assign sound_alarm = |ringing;

endmodule

// File: tb/tb_multi_alarm_core.sv
// tb/tb_multi_alarm_core.sv - vector table, corner sequences and random run against a minute-based model
module tb_multi_alarm_core;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int SNZ = 9;

    logic          MCLK = 1'b0;
    logic          reset = 1'b1;
    logic          one_minute, load_time, load_alarm, alarm_en_in;
    logic          do_snooze, stop_alarm, show_alarm;
    logic [15:0]   time_in, alarm_in;
    logic [SW-1:0] alarm_sel, show_sel;

    logic [15:0]   ct_a, disp_a, ct_b, disp_b;
    logic [N-1:0]  ring_a, ring_b;
    logic          snd_a, snd_b;
    logic [SW-1:0] act_a, act_b;

    int total = 0;
    int bad   = 0;

    multi_alarm_core #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(3)) dut_a (
        .MCLK(MCLK), .reset(reset), .one_minute(one_minute), .load_time(load_time),
        .time_in(time_in), .load_alarm(load_alarm), .alarm_sel(alarm_sel),
        .alarm_in(alarm_in), .alarm_en_in(alarm_en_in), .do_snooze(do_snooze),
        .stop_alarm(stop_alarm), .show_alarm(show_alarm), .show_sel(show_sel),
        .current_time(ct_a), .display(disp_a), .ringing(ring_a),
        .sound_alarm(snd_a), .active_alarm(act_a));

    multi_alarm_core #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(0)) dut_b (
        .MCLK(MCLK), .reset(reset), .one_minute(one_minute), .load_time(load_time),
        .time_in(time_in), .load_alarm(load_alarm), .alarm_sel(alarm_sel),
        .alarm_in(alarm_in), .alarm_en_in(alarm_en_in), .do_snooze(do_snooze),
        .stop_alarm(stop_alarm), .show_alarm(show_alarm), .show_sel(show_sel),
        .current_time(ct_b), .display(disp_b), .ringing(ring_b),
        .sound_alarm(snd_b), .active_alarm(act_b));

    always #5 MCLK = ~MCLK;

    // reference model: time as minutes-of-day, channels as 0=idle 1=ringing 2=snoozing
    int          mt;
    int          am   [N];
    bit          aen  [N];
    logic [15:0] araw [N];
    int          st [2][N];
    int          rc [2][N];
    int          sc [2][N];
    logic [15:0] dm;
    int          tmo [2] = '{3, 0};

    function automatic int to_min(input logic [15:0] b);
        int h1, h0, m1, m0;
        h1 = int'(b[15:12]); h0 = int'(b[11:8]); m1 = int'(b[7:4]); m0 = int'(b[3:0]);
        if (h1 > 9 || h0 > 9 || m1 > 9 || m0 > 9) return -1;
        if (h1 * 10 + h0 > 23 || m1 * 10 + m0 > 59) return -1;
        return (h1 * 10 + h0) * 60 + m1 * 10 + m0;
    endfunction

    function automatic logic [15:0] to_bcd(input int x);
        int h, m;
        h = x / 60;
        m = x % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic model_reset();
        mt = 0;
        dm = 16'h0000;
        for (int c = 0; c < N; c++) begin
            am[c] = 0; aen[c] = 1'b0; araw[c] = 16'h0000;
            for (int d = 0; d < 2; d++) begin
                st[d][c] = 0; rc[d][c] = 0; sc[d][c] = 0;
            end
        end
    endtask

    task automatic model_step();
        int nt, ta;
        bit lt_ok;
        dm    = show_alarm ? araw[show_sel] : to_bcd(mt);
        lt_ok = load_time && (to_min(time_in) >= 0);
        ta    = to_min(alarm_in);
        nt    = (mt + 1) % 1440;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                if (load_alarm && int'(alarm_sel) == c && ta >= 0) begin
                    st[d][c] = 0; rc[d][c] = 0; sc[d][c] = 0;
                end else if (stop_alarm) begin
                    st[d][c] = 0;
                end else if (do_snooze && st[d][c] == 1) begin
                    st[d][c] = 2; sc[d][c] = SNZ;
                end else if (one_minute) begin
                    if (st[d][c] == 0) begin
                        if (aen[c] && !lt_ok && am[c] == nt) begin
                            st[d][c] = 1; rc[d][c] = 0;
                        end
                    end else if (st[d][c] == 1) begin
                        rc[d][c]++;
                        if (tmo[d] != 0 && rc[d][c] == tmo[d]) st[d][c] = 0;
                    end else begin
                        if (sc[d][c] == 1) begin
                            st[d][c] = 1; rc[d][c] = 0;
                        end else begin
                            sc[d][c]--;
                        end
                    end
                end
            end
        end
        if (load_alarm && ta >= 0) begin
            am[alarm_sel] = ta; araw[alarm_sel] = alarm_in; aen[alarm_sel] = alarm_en_in;
        end
        if (lt_ok) mt = to_min(time_in);
        else if (one_minute) mt = nt;
    endtask

    function automatic logic [63:0] model_vec(input int d);
        logic [N-1:0]  r;
        logic [SW-1:0] a;
        r = '0;
        a = '0;
        for (int c = 0; c < N; c++) r[c] = (st[d][c] == 1);
        for (int c = N - 1; c >= 0; c--) if (r[c]) a = SW'(c);
        return 64'({to_bcd(mt), dm, r, |r, a});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        one_minute = 1'b0; load_time = 1'b0; load_alarm = 1'b0; alarm_en_in = 1'b0;
        do_snooze = 1'b0; stop_alarm = 1'b0; show_alarm = 1'b0;
        time_in = 16'h0000; alarm_in = 16'h0000; alarm_sel = '0; show_sel = '0;
    endtask

    task automatic tick();
        @(posedge MCLK);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    typedef struct {
        logic          lt;
        logic [15:0]   ti;
        logic          om;
        logic          la;
        logic [SW-1:0] as;
        logic [15:0]   ai;
        logic          ae;
        logic          sz;
        logic          sp;
        logic [15:0]   et;
        logic [N-1:0]  er;
        logic [SW-1:0] ea;
    } vec_t;

    function automatic vec_t mk(input int lt, ti, om, la, as, ai, ae, sz, sp, et, er, ea);
        vec_t v;
        v.lt = lt[0]; v.ti = ti[15:0]; v.om = om[0]; v.la = la[0]; v.as = as[SW-1:0];
        v.ai = ai[15:0]; v.ae = ae[0]; v.sz = sz[0]; v.sp = sp[0];
        v.et = et[15:0]; v.er = er[N-1:0]; v.ea = ea[SW-1:0];
        return v;
    endfunction

    task automatic set_cycle(input vec_t v);
        load_time = v.lt; time_in = v.ti; one_minute = v.om; load_alarm = v.la;
        alarm_sel = v.as; alarm_in = v.ai; alarm_en_in = v.ae;
        do_snooze = v.sz; stop_alarm = v.sp;
        tick();
        clear_in();
    endtask

    task automatic cyc(input int lt, ti, om, la, as, ai, ae, sz, sp);
        set_cycle(mk(lt, ti, om, la, as, ai, ae, sz, sp, 0, 0, 0));
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    vec_t tbl [14];

    initial begin
        int drop;

        tbl[0]  = mk(1, 'h2359, 0, 0, 0, 0,       0, 0, 0, 'h2359, 'b0000, 0);
        tbl[1]  = mk(0, 0,      1, 0, 0, 0,       0, 0, 0, 'h0000, 'b0000, 0);
        tbl[2]  = mk(1, 'h2460, 0, 0, 0, 0,       0, 0, 0, 'h0000, 'b0000, 0);
        tbl[3]  = mk(0, 0,      0, 1, 2, 'h0700,  1, 0, 0, 'h0000, 'b0000, 0);
        tbl[4]  = mk(0, 0,      0, 1, 1, 'h0700,  0, 0, 0, 'h0000, 'b0000, 0);
        tbl[5]  = mk(1, 'h0659, 0, 0, 0, 0,       0, 0, 0, 'h0659, 'b0000, 0);
        tbl[6]  = mk(0, 0,      1, 0, 0, 0,       0, 0, 0, 'h0700, 'b0100, 2);
        tbl[7]  = mk(0, 0,      0, 0, 0, 0,       0, 1, 1, 'h0700, 'b0000, 0);
        tbl[8]  = mk(1, 'h1234, 1, 0, 0, 0,       0, 0, 0, 'h1234, 'b0000, 0);
        tbl[9]  = mk(0, 0,      0, 1, 0, 'h1240,  1, 0, 0, 'h1234, 'b0000, 0);
        tbl[10] = mk(0, 0,      0, 1, 3, 'h1240,  1, 0, 0, 'h1234, 'b0000, 0);
        tbl[11] = mk(1, 'h1239, 0, 0, 0, 0,       0, 0, 0, 'h1239, 'b0000, 0);
        tbl[12] = mk(0, 0,      1, 0, 0, 0,       0, 0, 0, 'h1240, 'b1001, 0);
        tbl[13] = mk(0, 0,      0, 0, 0, 0,       0, 0, 1, 'h1240, 'b0000, 0);

        clear_in();
        reset = 1'b1;
        tick();
        check("reset_a", 64'({ct_a, disp_a, ring_a, snd_a, act_a}), 64'h0);
        check("reset_b", 64'({ct_b, disp_b, ring_b, snd_b, act_b}), 64'h0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_cycle(tbl[i]);
            check($sformatf("vec%0d_time", i), 64'(ct_a), 64'(tbl[i].et));
            check($sformatf("vec%0d_ring", i), 64'({ring_a, snd_a}), 64'({tbl[i].er, |tbl[i].er}));
            check($sformatf("vec%0d_active", i), 64'(act_a), 64'(tbl[i].ea));
        end

        // snooze length, stop mid-snooze, snooze+stop in one cycle
        do_reset();
        cyc(0, 0, 0, 1, 2, 'h0700, 1, 0, 0);
        cyc(1, 'h0659, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("snz_trigger", 64'(ring_a), 64'(4'b0100));
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("snz_silent", 64'({ring_a, snd_a}), 64'h0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("snz_8th_silent", 64'(ring_a), 64'h0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("snz_9th_rings", 64'({ring_a, ring_b}), 64'({4'b0100, 4'b0100}));
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("snz_stop_no_rering", 64'({ring_a, ring_b}), 64'h0);
        cyc(1, 'h0659, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("snz_retrigger", 64'(ring_a), 64'(4'b0100));
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("snz_stop_priority", 64'({ring_a, ring_b}), 64'h0);

        // timeout=3 on dut_a, timeout disabled on dut_b
        do_reset();
        cyc(0, 0, 0, 1, 2, 'h0700, 1, 0, 0);
        cyc(1, 'h0659, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drop = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
            if (ring_b !== 4'b0100) drop++;
            if (i == 2) check("timeout_2nd_still_ringing", 64'(ring_a), 64'(4'b0100));
            if (i == 3) check("timeout_3rd_idle", 64'({ring_a, snd_a}), 64'h0);
        end
        check("timeout0_hold_300", 64'(drop), 64'h0);
        check("timeout0_time", 64'(ct_b), 64'h1200);

        // display selection, then asynchronous reset mid-ring
        do_reset();
        cyc(0, 0, 0, 1, 2, 'h0700, 1, 0, 0);
        cyc(1, 'h0659, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        show_alarm = 1'b1;
        show_sel   = 2'd2;
        tick();
        check("display_alarm2", 64'({disp_a, act_a}), 64'({16'h0700, 2'd2}));
        @(negedge MCLK);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_a", 64'({ct_a, disp_a, ring_a, snd_a, act_a}), 64'h0);
        check("async_reset_b", 64'({ct_b, disp_b, ring_b, snd_b, act_b}), 64'h0);
        tick();
        reset = 1'b0;
        clear_in();
        tick();
        check("display_after_reset", 64'(disp_a), 64'h0);

        // random run against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            one_minute  = ($urandom_range(0, 1) == 0);
            load_time   = ($urandom_range(0, 39) == 0);
            time_in     = ($urandom_range(0, 1) == 0) ? to_bcd(int'($urandom_range(0, 1439))) : 16'($urandom);
            load_alarm  = ($urandom_range(0, 9) == 0);
            alarm_sel   = SW'($urandom);
            alarm_in    = ($urandom_range(0, 3) != 0) ? to_bcd((mt + int'($urandom_range(1, 12))) % 1440)
                                                      : 16'($urandom);
            alarm_en_in = ($urandom_range(0, 3) != 0);
            do_snooze   = ($urandom_range(0, 9) == 0);
            stop_alarm  = ($urandom_range(0, 49) == 0);
            show_alarm  = ($urandom_range(0, 1) == 0);
            show_sel    = SW'($urandom);
            tick();
            check($sformatf("rand%0d_a", i), 64'({ct_a, disp_a, ring_a, snd_a, act_a}), model_vec(0));
            check($sformatf("rand%0d_b", i), 64'({ct_b, disp_b, ring_b, snd_b, act_b}), model_vec(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
